// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the four-digit BCD stopwatch.
// Imported by the stopwatch top level.
package stopwatch_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int DIGITS_W   = DIGIT_W * NUM_DIGITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_FULL  = 2'd3;

    localparam logic [DIGITS_W-1:0] BCD_MAX   = 16'h9999;
    localparam logic [DIGIT_W-1:0]  DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        FULL  = ST_FULL
    } sw_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-FF synchroniser, stability counter, and a
// one-cycle pulse on each accepted press (0->1 of the debounced level).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_p
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    // Any sample that agrees with the accepted level restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level  = level_q;
    assign rise_p = level_q & ~level_dly_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (SS.hh) with debounced start/stop and clear buttons;
// drives the digit word of the seven-segment display driver.
module bcd_stopwatch #(
    parameter int TICK_DIV        = 250_000,
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        ovf
);

    import stopwatch_pkg::*;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_e            state_q;
    sw_state_e            state_d;
    logic [PW-1:0]        presc_q;
    logic [PW-1:0]        presc_d;
    logic [DIGITS_W-1:0]  digits_q;
    logic [DIGITS_W-1:0]  digits_d;
    logic [DIGITS_W-1:0]  digits_inc;
    logic [NUM_DIGITS-1:0] carry;
    logic                 tick;
    logic                 start_p;
    logic                 clear_p;
    logic                 start_level;
    logic                 clear_level;
    logic                 unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_start),
        .level  (start_level),
        .rise_p (start_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_clear),
        .level  (clear_level),
        .rise_p (clear_p)
    );

    assign unused_levels = start_level ^ clear_level;

    // Ripple-carry decimal increment, one nibble per generate slice.
    assign carry[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [DIGIT_W-1:0] nib;
            assign nib = digits_q[gi*DIGIT_W +: DIGIT_W];
            assign digits_inc[gi*DIGIT_W +: DIGIT_W] =
                !carry[gi]          ? nib :
                (nib == DIGIT_MAX)  ? '0  : nib + 1'b1;
            if (gi < NUM_DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] && (nib == DIGIT_MAX);
            end
        end
    endgenerate

    assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            digits_q <= digits_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        digits_d = digits_q;
        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (start_p) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    // A tick at 99.99 saturates; a simultaneous start press is dropped.
                    if (digits_q == BCD_MAX) begin
                        state_d = FULL;
                    end else begin
                        digits_d = digits_inc;
                        if (start_p) begin
                            state_d = PAUSE;
                        end
                    end
                end else if (start_p) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (start_p) begin
                    state_d = RUN;
                end
            end
            FULL: begin
                presc_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear_p) begin
            state_d  = IDLE;
            presc_d  = '0;
            digits_d = '0;
        end
    end

    assign digits  = digits_q;
    assign running = (state_q == RUN);
    assign ovf     = (state_q == FULL);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: expected digit values are queued
// ahead of time and popped whenever the displayed word changes.
module tb_bcd_stopwatch;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    // Edges from the first edge after a button change to the FSM reacting.
    localparam int LAT      = DEB + 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic        ovf;

    bcd_stopwatch #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .digits    (digits),
        .running   (running),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    int          model_cnt   = 0;

    int          cyc             = 0;
    logic [15:0] last_digits     = 16'h0000;
    logic        last_running    = 1'b0;
    int          last_change_cyc = 0;
    int          run_rise_cyc    = -1;
    int          run_fall_cyc    = -1;
    int          run_rises       = 0;
    logic [15:0] mon_exp;
    logic        mon_bad;

    int          run_start_cyc   = 0;
    int          resume_cyc      = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Scoreboard consumer: samples 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (running !== last_running) begin
            if (running === 1'b1) begin
                run_rises++;
                run_rise_cyc = cyc;
            end else begin
                run_fall_cyc = cyc;
            end
            last_running = running;
        end
        if (digits !== last_digits) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_unexpected: digits=%h at cycle %0d, expected no change", digits, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (digits !== mon_exp) begin
                    miscompares++;
                    $display("FAIL scoreboard: digits=%h at cycle %0d, expected %h", digits, cyc, mon_exp);
                end
            end
            mon_bad = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (digits[i*4 +: 4] > 4'd9) mon_bad = 1'b1;
            end
            vectors++;
            if (mon_bad !== 1'b0) begin
                miscompares++;
                $display("FAIL bcd_nibble_range: digits=%h, expected every nibble 0-9", digits);
            end
            last_digits     = digits;
            last_change_cyc = cyc;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            model_cnt++;
            exp_q.push_back(to_bcd(model_cnt));
        end
    endtask

    task automatic push_clear();
        if (model_cnt != 0) exp_q.push_back(16'h0000);
        model_cnt = 0;
    endtask

    task automatic test_reset();
        int k;
        int r;
        int rises0;
        repeat (2) @(negedge clk);
        vectors++; if (digits !== 16'h0000) begin miscompares++; $display("FAIL reset_digits: digits=%h expected 0000", digits); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_running: running=%b expected 0", running); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: ovf=%b expected 0", ovf); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_idle_running: running=%b expected 0", running); end
        // Run three ticks, then pull reset mid-count.
        k = cyc;
        r = k + 1 + LAT;
        btn_start = 1'b1;
        push_ticks(3);
        wait_until(k + 7);
        btn_start = 1'b0;
        wait_until(r + 14);
        vectors++; if (run_rise_cyc !== r) begin miscompares++; $display("FAIL reset_start_edge: running rose at %0d expected %0d", run_rise_cyc, r); end
        vectors++; if (digits !== 16'h0003) begin miscompares++; $display("FAIL reset_precount: digits=%h expected 0003", digits); end
        push_clear();
        rst_n = 1'b0;
        #1;
        vectors++; if (digits !== 16'h0000) begin miscompares++; $display("FAIL reset_async_digits: digits=%h expected 0000", digits); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_async_running: running=%b expected 0", running); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_async_ovf: ovf=%b expected 0", ovf); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rises0 = run_rises;
        repeat (30) @(negedge clk);
        vectors++; if (run_rises !== rises0) begin miscompares++; $display("FAIL reset_no_restart: run starts=%0d expected %0d", run_rises, rises0); end
        vectors++; if (digits !== 16'h0000) begin miscompares++; $display("FAIL reset_hold_digits: digits=%h expected 0000", digits); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL reset_scoreboard_drain: %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_bounce();
        int k;
        int rises0;
        rises0 = run_rises;
        for (int i = 0; i < 5; i++) begin
            btn_start = 1'b1;
            repeat (2) @(negedge clk);
            btn_start = 1'b0;
            repeat (2) @(negedge clk);
        end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL bounce_rejected: running=%b expected 0", running); end
        k = cyc;
        run_start_cyc = k + 1 + LAT;
        btn_start = 1'b1;
        push_ticks(100);
        wait_until(k + 30);
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL bounce_running: running=%b expected 1", running); end
        vectors++; if (run_rises !== rises0 + 1) begin miscompares++; $display("FAIL bounce_one_pulse: run starts=%0d expected %0d", run_rises, rises0 + 1); end
        vectors++; if (run_rise_cyc !== run_start_cyc) begin miscompares++; $display("FAIL bounce_start_edge: running rose at %0d expected %0d", run_rise_cyc, run_start_cyc); end
        btn_start = 1'b0;
    endtask

    task automatic test_carry();
        int r;
        r = run_start_cyc;
        wait_until(r + 4 * 9);
        vectors++; if (digits !== 16'h0009) begin miscompares++; $display("FAIL carry_0009: digits=%h expected 0009", digits); end
        wait_until(r + 4 * 10);
        vectors++; if (digits !== 16'h0010) begin miscompares++; $display("FAIL carry_0010: digits=%h expected 0010", digits); end
        wait_until(r + 4 * 99);
        vectors++; if (digits !== 16'h0099) begin miscompares++; $display("FAIL carry_0099: digits=%h expected 0099", digits); end
        // Press so the pause lands two clocks after tick 100 (prescaler retains 2).
        btn_start = 1'b1;
        wait_until(r + 4 * 100);
        vectors++; if (digits !== 16'h0100) begin miscompares++; $display("FAIL carry_0100: digits=%h expected 0100", digits); end
        wait_until(r + 4 * 99 + 7);
        btn_start = 1'b0;
        vectors++; if (run_fall_cyc !== r + 4 * 99 + 1 + LAT) begin miscompares++; $display("FAIL carry_pause_edge: running fell at %0d expected %0d", run_fall_cyc, r + 4 * 99 + 1 + LAT); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL carry_tick_count: %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_pause();
        int k;
        repeat (50) @(negedge clk);
        vectors++; if (digits !== 16'h0100) begin miscompares++; $display("FAIL pause_frozen: digits=%h expected 0100", digits); end
        vectors++; if (last_change_cyc !== run_start_cyc + 400) begin miscompares++; $display("FAIL pause_no_change: last change at %0d expected %0d", last_change_cyc, run_start_cyc + 400); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL pause_running: running=%b expected 0", running); end
        k = cyc;
        resume_cyc = k + 1 + LAT;
        btn_start = 1'b1;
        push_ticks(1);
        wait_until(k + 7);
        btn_start = 1'b0;
        wait_until(resume_cyc + 2);
        vectors++; if (run_rise_cyc !== resume_cyc) begin miscompares++; $display("FAIL pause_resume_edge: running rose at %0d expected %0d", run_rise_cyc, resume_cyc); end
        vectors++; if (last_change_cyc !== resume_cyc + 2) begin miscompares++; $display("FAIL pause_resume_tick: tick at %0d expected %0d", last_change_cyc, resume_cyc + 2); end
        vectors++; if (digits !== 16'h0101) begin miscompares++; $display("FAIL pause_resume_value: digits=%h expected 0101", digits); end
    endtask

    task automatic test_simultaneous();
        int k;
        int hit;
        wait_until(resume_cyc + 3);
        k = cyc;
        hit = k + 1 + LAT;
        btn_start = 1'b1;
        btn_clear = 1'b1;
        push_ticks(1);
        push_clear();
        wait_until(k + 7);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        wait_until(hit + 20);
        vectors++; if (run_fall_cyc !== hit) begin miscompares++; $display("FAIL simul_edge: running fell at %0d expected %0d", run_fall_cyc, hit); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL simul_running: running=%b expected 0", running); end
        vectors++; if (digits !== 16'h0000) begin miscompares++; $display("FAIL simul_digits: digits=%h expected 0000", digits); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL simul_ovf: ovf=%b expected 0", ovf); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL simul_scoreboard_drain: %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_saturate();
        int k;
        int r;
        k = cyc;
        r = k + 1 + LAT;
        btn_start = 1'b1;
        push_ticks(9999);
        wait_until(k + 7);
        btn_start = 1'b0;
        wait_until(r + 4 * 9998);
        vectors++; if (digits !== 16'h9998) begin miscompares++; $display("FAIL sat_9998: digits=%h expected 9998", digits); end
        wait_until(r + 4 * 9999);
        vectors++; if (digits !== 16'h9999) begin miscompares++; $display("FAIL sat_9999: digits=%h expected 9999", digits); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sat_ovf_early: ovf=%b expected 0", ovf); end
        wait_until(r + 4 * 10000);
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL sat_ovf: ovf=%b expected 1", ovf); end
        vectors++; if (run_fall_cyc !== r + 4 * 10000) begin miscompares++; $display("FAIL sat_full_edge: running fell at %0d expected %0d", run_fall_cyc, r + 4 * 10000); end
        repeat (10) @(negedge clk);
        k = cyc;
        btn_start = 1'b1;
        wait_until(k + 7);
        btn_start = 1'b0;
        wait_until(k + 40);
        vectors++; if (digits !== 16'h9999) begin miscompares++; $display("FAIL sat_hold_digits: digits=%h expected 9999", digits); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL sat_start_ignored: ovf=%b expected 1", ovf); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL sat_hold_running: running=%b expected 0", running); end
        k = cyc;
        push_clear();
        btn_clear = 1'b1;
        wait_until(k + 7);
        btn_clear = 1'b0;
        wait_until(k + 10);
        vectors++; if (last_change_cyc !== k + 1 + LAT) begin miscompares++; $display("FAIL sat_clear_edge: cleared at %0d expected %0d", last_change_cyc, k + 1 + LAT); end
        vectors++; if (digits !== 16'h0000) begin miscompares++; $display("FAIL sat_clear_digits: digits=%h expected 0000", digits); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sat_clear_ovf: ovf=%b expected 0", ovf); end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL sat_scoreboard_drain: %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_carry();
        test_pause();
        test_simultaneous();
        test_saturate();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
